// File: rtl/altair_pkg.sv
// Shared definitions for the serial loader slice.
//   SYNC_BYTE   : first byte of every load frame
//   ld_state_e  : frame decoder states
//   rx_state_e  : serial receiver states
//   baud_div()  : rounded clocks per oversample tick
package altair_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'h55;

    typedef enum logic [2:0] {
        IDLE,
        ADDR_H,
        ADDR_L,
        LEN,
        DATA,
        CHK
    } ld_state_e;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_WAIT_HIGH
    } rx_state_e;

    function automatic int unsigned baud_div(input int unsigned clk_hz,
                                             input int unsigned baud,
                                             input int unsigned os);
        return (clk_hz + (baud * os) / 2) / (baud * os);
    endfunction

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 serial receiver: 2-FF synchronizer, oversample tick divider and
// mid-bit sampler.
//   clk, reset : system clock, async active-high reset
//   rx         : serial line, idle high, asynchronous to clk
//   rx_byte    : received byte, valid while rx_valid pulses
//   rx_valid   : one-clk pulse when a byte with a good stop bit arrives
//   frame_err  : one-clk pulse when the stop bit is sampled low
module uart_rx_core
    import altair_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 50_000_000,
    parameter int unsigned BAUD       = 19_200,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       frame_err
);

    localparam int unsigned DIV    = baud_div(CLK_HZ, BAUD, OVERSAMPLE);
    localparam int unsigned DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned TICK_W = $clog2(OVERSAMPLE + 1);

    rx_state_e          state_q;
    logic               rx_meta_q, rx_sync_q, rx_prev_q;
    logic [DIV_W-1:0]   div_q;
    logic [TICK_W-1:0]  tick_q;
    logic [2:0]         bit_q;
    logic [7:0]         shift_q;
    logic               tick;

    assign tick = (div_q == DIV_W'(DIV - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= RX_IDLE;
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
            div_q     <= '0;
            tick_q    <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            rx_byte   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            div_q     <= tick ? '0 : div_q + 1'b1;
            if (tick) tick_q <= tick_q + 1'b1;

            case (state_q)
                RX_IDLE: begin
                    // Divider phase is aligned to the detected falling edge.
                    div_q  <= '0;
                    tick_q <= '0;
                    if (rx_prev_q && !rx_sync_q) state_q <= RX_START;
                end
                RX_START: begin
                    if (tick && tick_q == TICK_W'(OVERSAMPLE / 2 - 1)) begin
                        tick_q  <= '0;
                        bit_q   <= '0;
                        state_q <= rx_sync_q ? RX_IDLE : RX_DATA;
                    end
                end
                RX_DATA: begin
                    if (tick && tick_q == TICK_W'(OVERSAMPLE - 1)) begin
                        tick_q  <= '0;
                        shift_q <= {rx_sync_q, shift_q[7:1]};
                        bit_q   <= bit_q + 3'd1;
                        if (bit_q == 3'd7) state_q <= RX_STOP;
                    end
                end
                RX_STOP: begin
                    if (tick && tick_q == TICK_W'(OVERSAMPLE - 1)) begin
                        tick_q <= '0;
                        if (rx_sync_q) begin
                            rx_byte  <= shift_q;
                            rx_valid <= 1'b1;
                            state_q  <= RX_IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            state_q   <= RX_WAIT_HIGH;
                        end
                    end
                end
                RX_WAIT_HIGH: begin
                    if (rx_sync_q) state_q <= RX_IDLE;
                end
                default: state_q <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/serial_loader.sv
// Serial load-frame decoder that writes host bytes straight into memory
// while holding the CPU off the bus.
// Frame: 0x55, AH, AL, LEN (0 = 256), DATA[LEN], CHK; sum of all but 0x55 is 0.
//   clk, reset  : system clock, async active-high reset
//   rx          : serial input from host
//   hlda, hold  : CPU bus grant handshake
//   mem_addr/mem_data/mem_we : memory write port, one-clk strobe
//   busy, done  : frame in progress / one-clk end-of-frame pulse
//   err_*       : sticky error flags, cleared by the next SYNC byte
module serial_loader
    import altair_pkg::*;
#(
    parameter int unsigned CLK_HZ       = 50_000_000,
    parameter int unsigned BAUD         = 19_200,
    parameter int unsigned OVERSAMPLE   = 16,
    parameter int unsigned TIMEOUT_CLKS = 50_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx,
    input  logic        hlda,
    output logic        hold,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_data,
    output logic        mem_we,
    output logic        busy,
    output logic        done,
    output logic        err_chk,
    output logic        err_frame,
    output logic        err_overrun,
    output logic        err_timeout
);

    localparam int unsigned TO_W = $clog2(TIMEOUT_CLKS + 1);

    logic [7:0] rx_byte;
    logic       rx_valid, rx_ferr;

    uart_rx_core #(
        .CLK_HZ     (CLK_HZ),
        .BAUD       (BAUD),
        .OVERSAMPLE (OVERSAMPLE)
    ) u_rx (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .rx_byte   (rx_byte),
        .rx_valid  (rx_valid),
        .frame_err (rx_ferr)
    );

    ld_state_e         state_q;
    logic [15:0]       addr_q;
    logic [8:0]        cnt_q;
    logic [7:0]        sum_q;
    logic [7:0]        pend_q;
    logic              pend_full_q;
    logic              chk_seen_q;
    logic [TO_W-1:0]   to_q;
    logic              hold_q, done_q;
    logic              err_chk_q, err_frame_q, err_overrun_q, err_timeout_q;
    logic              wr_fire, to_hit, abort;

    // The write strobe follows hlda combinationally so it can never be
    // asserted in a cycle where the grant is low.
    assign wr_fire = hold_q & hlda & pend_full_q;
    assign to_hit  = (to_q == TO_W'(TIMEOUT_CLKS - 1)) && !rx_valid;
    assign abort   = (state_q != IDLE) && (rx_ferr || to_hit);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            cnt_q         <= '0;
            sum_q         <= '0;
            pend_q        <= '0;
            pend_full_q   <= 1'b0;
            chk_seen_q    <= 1'b0;
            to_q          <= '0;
            hold_q        <= 1'b0;
            done_q        <= 1'b0;
            err_chk_q     <= 1'b0;
            err_frame_q   <= 1'b0;
            err_overrun_q <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (wr_fire) begin
                addr_q      <= addr_q + 16'd1;
                pend_full_q <= 1'b0;
            end
            if (state_q == IDLE || rx_valid) to_q <= '0;
            else                             to_q <= to_q + 1'b1;
            if (rx_ferr) err_frame_q <= 1'b1;

            if (abort) begin
                if (!rx_ferr) err_timeout_q <= 1'b1;
                hold_q      <= 1'b0;
                pend_full_q <= 1'b0;
                state_q     <= IDLE;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (rx_valid && rx_byte == SYNC_BYTE) begin
                            err_chk_q     <= 1'b0;
                            err_frame_q   <= 1'b0;
                            err_overrun_q <= 1'b0;
                            err_timeout_q <= 1'b0;
                            hold_q        <= 1'b1;
                            state_q       <= ADDR_H;
                        end
                    end
                    ADDR_H: if (rx_valid) begin
                        addr_q[15:8] <= rx_byte;
                        sum_q        <= rx_byte;
                        state_q      <= ADDR_L;
                    end
                    ADDR_L: if (rx_valid) begin
                        addr_q[7:0] <= rx_byte;
                        sum_q       <= sum_q + rx_byte;
                        state_q     <= LEN;
                    end
                    LEN: if (rx_valid) begin
                        cnt_q      <= (rx_byte == 8'd0) ? 9'd256 : {1'b0, rx_byte};
                        sum_q      <= sum_q + rx_byte;
                        chk_seen_q <= 1'b0;
                        state_q    <= DATA;
                    end
                    DATA: if (rx_valid) begin
                        // Counter tracks data bytes received (kept or dropped),
                        // so the CHK byte is never mistaken for data while the
                        // last data byte is still waiting for the bus.
                        sum_q <= sum_q + rx_byte;
                        cnt_q <= cnt_q - 9'd1;
                        if (pend_full_q && !wr_fire) begin
                            err_overrun_q <= 1'b1;
                        end else begin
                            pend_q      <= rx_byte;
                            pend_full_q <= 1'b1;
                        end
                        if (cnt_q == 9'd1) state_q <= CHK;
                    end
                    CHK: begin
                        if (rx_valid && !chk_seen_q) begin
                            sum_q      <= sum_q + rx_byte;
                            chk_seen_q <= 1'b1;
                        end
                        if (chk_seen_q && !pend_full_q) begin
                            err_chk_q <= (sum_q != 8'd0);
                            done_q    <= 1'b1;
                            hold_q    <= 1'b0;
                            state_q   <= IDLE;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign hold        = hold_q;
    assign mem_addr    = addr_q;
    assign mem_data    = pend_q;
    assign mem_we      = wr_fire;
    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign err_chk     = err_chk_q;
    assign err_frame   = err_frame_q;
    assign err_overrun = err_overrun_q;
    assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_serial_loader.sv
// Self-checking bench for serial_loader. Clock rates are scaled so one
// oversample tick is one clock (16 clocks per bit); timeout is 1000 clocks.
module tb_serial_loader;

    localparam int unsigned CLK_HZ = 250_000;
    localparam int unsigned BAUD   = 15_625;
    localparam int unsigned OS     = 16;
    localparam int unsigned TO     = 1000;
    localparam int          BIT_CLKS = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        rx;
    logic        hlda;
    logic        hold;
    logic [15:0] mem_addr;
    logic [7:0]  mem_data;
    logic        mem_we, busy, done;
    logic        err_chk, err_frame, err_overrun, err_timeout;

    always #5 clk = ~clk;

    serial_loader #(
        .CLK_HZ       (CLK_HZ),
        .BAUD         (BAUD),
        .OVERSAMPLE   (OS),
        .TIMEOUT_CLKS (TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rx          (rx),
        .hlda        (hlda),
        .hold        (hold),
        .mem_addr    (mem_addr),
        .mem_data    (mem_data),
        .mem_we      (mem_we),
        .busy        (busy),
        .done        (done),
        .err_chk     (err_chk),
        .err_frame   (err_frame),
        .err_overrun (err_overrun),
        .err_timeout (err_timeout)
    );

    // CPU model: grants the bus two clocks after hold, unless grant is withheld.
    logic h1 = 1'b0, h2 = 1'b0;
    logic grant_en;
    always @(posedge clk or posedge reset) begin
        if (reset) begin h1 <= 1'b0; h2 <= 1'b0; end
        else begin h1 <= hold; h2 <= h1; end
    end
    assign hlda = grant_en & h2;

    typedef struct packed { logic [15:0] a; logic [7:0] d; } wr_t;
    wr_t got_wr[$];
    wr_t exp_wr[$];
    logic [7:0] tx_q[$];
    logic [7:0] dbuf[256];

    int errors = 0, checks = 0;
    int done_cnt = 0, we_nohlda = 0, cyc = 0, ef_cyc = 0, hf_cyc = -100;
    logic ef_prev = 1'b0, hold_prev = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (mem_we) begin
            got_wr.push_back({mem_addr, mem_data});
            if (!hlda) we_nohlda++;
        end
        if (done) done_cnt++;
        if (err_frame && !ef_prev) ef_cyc = cyc;
        if (!hold && hold_prev) hf_cyc = cyc;
        ef_prev   = err_frame;
        hold_prev = hold;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rx = 1'b0; wait_clks(BIT_CLKS);
        for (int i = 0; i < 8; i++) begin
            rx = b[i]; wait_clks(BIT_CLKS);
        end
        rx = stop; wait_clks(BIT_CLKS);
        rx = 1'b1; wait_clks(BIT_CLKS);
    endtask

    task automatic send_tx();
        foreach (tx_q[i]) send_byte(tx_q[i], 1'b1);
    endtask

    // Reference model: frame bytes, expected writes (address wraps at 16 bits)
    // and checksum verdict computed straight from the frame rules.
    task automatic build_frame(input logic [15:0] addr, input logic [7:0] len,
                               input logic auto_chk, input logic [7:0] chk_in,
                               output logic exp_err);
        int n;
        logic [7:0]  sum, chk;
        logic [15:0] a;
        n = (len == 8'd0) ? 256 : int'(len);
        tx_q.delete();
        exp_wr.delete();
        tx_q.push_back(8'h55);
        tx_q.push_back(addr[15:8]);
        tx_q.push_back(addr[7:0]);
        tx_q.push_back(len);
        sum = addr[15:8] + addr[7:0] + len;
        for (int i = 0; i < n; i++) begin
            tx_q.push_back(dbuf[i]);
            sum = sum + dbuf[i];
            a = addr + 16'(i);
            exp_wr.push_back({a, dbuf[i]});
        end
        chk = auto_chk ? ((8'd0 - sum) ^ chk_in) : chk_in;
        tx_q.push_back(chk);
        exp_err = ((sum + chk) != 8'd0);
    endtask

    task automatic compare_writes(input string name);
        int n;
        check({name, " nwr"}, got_wr.size(), exp_wr.size());
        n = (got_wr.size() < exp_wr.size()) ? got_wr.size() : exp_wr.size();
        for (int i = 0; i < n; i++) check({name, " wr"}, 32'(got_wr[i]), 32'(exp_wr[i]));
    endtask

    task automatic run_frame(input string name, input logic exp_chk, input logic exp_ovr);
        int d0;
        d0 = done_cnt;
        got_wr.delete();
        send_tx();
        for (int k = 0; k < 200 && done_cnt == d0; k++) wait_clks(1);
        wait_clks(2);
        check({name, " done"}, 32'(done_cnt - d0), 1);
        check({name, " hold"}, 32'(hold), 0);
        check({name, " busy"}, 32'(busy), 0);
        check({name, " err_chk"}, 32'(err_chk), 32'(exp_chk));
        check({name, " err_overrun"}, 32'(err_overrun), 32'(exp_ovr));
        check({name, " err_frame"}, 32'(err_frame), 0);
        check({name, " err_timeout"}, 32'(err_timeout), 0);
        compare_writes(name);
    endtask

    typedef struct {
        string       name;
        logic [15:0] addr;
        logic [7:0]  len;
        logic [23:0] d;      // first data byte in the top octet
        logic [7:0]  chk;
        logic        exp_err_chk;
    } vec_t;

    vec_t vecs[3];

    function automatic logic [31:0] all_outs();
        return {4'b0, hold, busy, mem_we, done, err_chk, err_frame, err_overrun,
                err_timeout, mem_addr, mem_data} & 32'h0FFF_FFFF;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic ee;
        int   d0;
        reset = 1'b1; rx = 1'b1; grant_en = 1'b1;
        vecs[0] = '{"normal",  16'h0100, 8'd3, 24'hAABBCC, 8'hCB, 1'b0};
        vecs[1] = '{"wrap",    16'hFFFF, 8'd2, 24'h112200, 8'hCD, 1'b0};
        vecs[2] = '{"bad_chk", 16'h0100, 8'd3, 24'hAABBCC, 8'h00, 1'b1};

        wait_clks(3);
        check("reset outputs", all_outs(), 0);
        reset = 1'b0;
        wait_clks(5);

        // Table-driven frames
        for (int v = 0; v < 3; v++) begin
            for (int i = 0; i < int'(vecs[v].len); i++) dbuf[i] = vecs[v].d[23 - 8*i -: 8];
            build_frame(vecs[v].addr, vecs[v].len, 1'b0, vecs[v].chk, ee);
            run_frame(vecs[v].name, vecs[v].exp_err_chk, 1'b0);
        end

        // Delayed grant: AA pending, BB dropped, CC written after grant
        grant_en = 1'b0;
        we_nohlda = 0;
        got_wr.delete();
        d0 = done_cnt;
        tx_q = '{8'h55, 8'h01, 8'h00, 8'h03, 8'hAA, 8'hBB};
        send_tx();
        check("grant nwr_before", got_wr.size(), 0);
        grant_en = 1'b1;
        send_byte(8'hCC, 1'b1);
        send_byte(8'hCB, 1'b1);
        wait_clks(4);
        exp_wr = '{{16'h0100, 8'hAA}, {16'h0101, 8'hCC}};
        compare_writes("grant");
        check("grant overrun", 32'(err_overrun), 1);
        check("grant err_chk", 32'(err_chk), 0);
        check("grant done", 32'(done_cnt - d0), 1);
        check("grant we_nohlda", 32'(we_nohlda), 0);

        // Framing error on AH aborts the frame
        got_wr.delete();
        hf_cyc = -100;
        d0 = done_cnt;
        send_byte(8'h55, 1'b1);
        send_byte(8'h01, 1'b0);
        wait_clks(2);
        check("ferr err_frame", 32'(err_frame), 1);
        check("ferr hold", 32'(hold), 0);
        check("ferr busy", 32'(busy), 0);
        check("ferr hold_latency", 32'(hf_cyc >= ef_cyc && hf_cyc - ef_cyc <= 2), 1);
        check("ferr nwr", got_wr.size(), 0);
        check("ferr done", 32'(done_cnt - d0), 0);
        for (int i = 0; i < 3; i++) dbuf[i] = vecs[0].d[23 - 8*i -: 8];
        build_frame(16'h0100, 8'd3, 1'b0, 8'hCB, ee);
        run_frame("after_ferr", 1'b0, 1'b0);

        // Inter-byte timeout
        got_wr.delete();
        d0 = done_cnt;
        tx_q = '{8'h55, 8'h01, 8'h00, 8'h03};
        send_tx();
        wait_clks(900);
        check("timeout early", 32'(err_timeout), 0);
        check("timeout hold_early", 32'(hold), 1);
        wait_clks(200);
        check("timeout flag", 32'(err_timeout), 1);
        check("timeout hold", 32'(hold), 0);
        check("timeout busy", 32'(busy), 0);
        check("timeout done", 32'(done_cnt - d0), 0);
        check("timeout nwr", got_wr.size(), 0);

        // Reset in the middle of DATA
        got_wr.delete();
        tx_q = '{8'h55, 8'h01, 8'h00, 8'h03, 8'hAA, 8'hBB};
        send_tx();
        wait_clks(3);
        check("midrst busy_before", 32'(busy), 1);
        reset = 1'b1;
        #1;
        check("midrst outputs", all_outs(), 0);
        wait_clks(5);
        check("midrst nwr", got_wr.size(), 2);
        reset = 1'b0;
        wait_clks(5);

        // Randomized frames against the model
        for (int r = 0; r < 4; r++) begin
            logic [15:0] a;
            logic [7:0]  len, cx;
            a   = (r == 1) ? 16'hFFFE : 16'($urandom);
            len = 8'($urandom_range(1, 4));
            for (int i = 0; i < int'(len); i++) dbuf[i] = 8'($urandom);
            cx  = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            build_frame(a, len, 1'b1, cx, ee);
            run_frame($sformatf("rand%0d", r), ee, 1'b0);
        end

        // LEN = 0 carries 256 bytes, crossing the top of the address space
        for (int i = 0; i < 256; i++) dbuf[i] = 8'($urandom);
        build_frame(16'hFFC0, 8'd0, 1'b1, 8'h00, ee);
        run_frame("len256", ee, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
